axil_config_master: RTL and testbench
=====================================

Name: axil_config_master

Overview:
- AXI4-Lite initiator that issues single register writes and reads into the configuration slave's control port, driven by a simple command/response stream.
- Used by on-chip sequencers, self-test logic and simulation benches to program configuration windows without the host.
- One transaction outstanding at a time, with a per-transaction response timeout.

Parameters:
- ADDR_LSB, $clog2(AXIL_DATA_BITS/8) = 3: byte-to-register address shift.
- TIMEOUT_CYCLES, 1024: maximum cycles spent waiting for bvalid or rvalid; 0 disables the timeout.
- STALE_CNT_BITS, 16: width of the stale-response counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid & ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AXI_ADDR_BITS-ADDR_LSB  register index, not a byte address
- cmd_data  in  AXIL_DATA_BITS  write data
- cmd_strb  in  AXIL_DATA_BITS/8  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_data  out  AXIL_DATA_BITS  read data; 0 for writes
- rsp_resp  out  2  AXI response code
- rsp_timeout  out  1  transaction timed out
- stale_cnt  out  STALE_CNT_BITS  saturating count of unexpected B/R beats
- axi_ctrl  AXI4L.m  -  AXI4-Lite master port

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - cmd_ready, rsp_valid, awvalid, wvalid and arvalid go to 0.
  - rsp_data, rsp_resp, rsp_timeout and stale_cnt go to 0; the timeout counter clears.
  - Reset mid-transaction abandons the transaction without a response.
- bready and rready: 0 during reset, then held constantly 1.
- Address mapping: awaddr/araddr = cmd_addr << ADDR_LSB, with the low ADDR_LSB bits 0. awprot/arprot = 0.
- IDLE:
  - cmd_ready = 1.
  - On command handshake, latch addr/data/strb. Write goes to WR_REQ; read goes to RD_REQ.
  - awvalid+wvalid, or arvalid, are registered and assert in the cycle after the handshake.
- WR_REQ:
  - awvalid and wvalid start high together.
  - Each drops in the cycle after its own handshake; AW and W may complete in either order or in the same cycle.
  - Neither valid is deasserted before its handshake.
  - When both are done, go to WR_RESP. A bvalid arriving in the same cycle as the last handshake is accepted as this transaction's response.
- WR_RESP: on bvalid, capture bresp, set rsp_data = 0, go to RESP.
- RD_REQ: arvalid high until arready, then go to RD_DATA. An rvalid coincident with the arready handshake is accepted.
- RD_DATA: on rvalid, capture rdata and rresp, go to RESP.
- Timeout:
  - Counter clears on entry to WR_RESP or RD_DATA and counts only in those states.
  - Reaching TIMEOUT_CYCLES-1 without a response: go to RESP with rsp_timeout = 1, rsp_resp = 2'b10, rsp_data = 0.
  - Address/data phases never time out (AXI forbids valid withdrawal).
- RESP:
  - rsp_valid = 1 and outputs are held stable until rsp_ready; next state is IDLE.
  - cmd_ready is 0 in RESP, so there is one bubble cycle before the next command.
- Stale beats:
  - Any bvalid outside WR_REQ/WR_RESP, or rvalid outside RD_REQ/RD_DATA, is dropped and increments stale_cnt.
  - stale_cnt saturates at all-ones and clears only on reset.
- cmd_* are ignored when cmd_ready = 0. A write with cmd_strb = 0 is still issued on AXI.

Test Plan:
- Write idx 0x5, data 0xDEADBEEF_01234567, strb 0xFF, slave ready immediately → awaddr = 0x28, wdata matches, rsp_resp = 0, rsp_timeout = 0, rsp_valid 4 cycles after the cmd handshake with zero-latency bvalid.
- Slave asserts awready 3 cycles before wready → awvalid drops the cycle after its handshake, wvalid stays high until its own, exactly one B accepted, rsp_resp = 0.
- Read idx 0x2, slave returns rdata 0xCAFE and rresp 2'b10 → araddr = 0x10, rsp_data = 0xCAFE, rsp_resp = 2'b10.
- TIMEOUT_CYCLES = 8, slave never asserts bvalid → rsp_valid with rsp_timeout = 1, rsp_resp = 2'b10 exactly 8 cycles after entering WR_RESP; a late bvalid afterwards raises stale_cnt to 1.
- rsp_ready held low 5 cycles with a new cmd_valid pending → rsp_* stable, cmd_ready = 0, new command accepted the cycle after returning to IDLE.
- Assert rst_n = 0 for 1 cycle while in RD_REQ → arvalid = 0 the next cycle, no rsp_valid, cmd_ready = 1 once back in IDLE.

Source files
------------

// File: rtl/axil_config_master.sv
// AXI4-Lite initiator: turns a single-command stream into register writes/reads
// on a configuration slave, one transaction outstanding, with response timeout.
module axil_config_master #(
  parameter int AXI_ADDR_BITS  = 32,
  parameter int AXIL_DATA_BITS = 64,
  parameter int ADDR_LSB       = $clog2(AXIL_DATA_BITS/8),
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STALE_CNT_BITS = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDR_BITS-ADDR_LSB-1:0] cmd_addr,
  input  logic [AXIL_DATA_BITS-1:0]     cmd_data,
  input  logic [AXIL_DATA_BITS/8-1:0]   cmd_strb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [AXIL_DATA_BITS-1:0]     rsp_data,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  output logic [STALE_CNT_BITS-1:0]     stale_cnt,
  output logic [AXI_ADDR_BITS-1:0]      axi_ctrl_awaddr,
  output logic [2:0]                    axi_ctrl_awprot,
  output logic                          axi_ctrl_awvalid,
  input  logic                          axi_ctrl_awready,
  output logic [AXIL_DATA_BITS-1:0]     axi_ctrl_wdata,
  output logic [AXIL_DATA_BITS/8-1:0]   axi_ctrl_wstrb,
  output logic                          axi_ctrl_wvalid,
  input  logic                          axi_ctrl_wready,
  input  logic [1:0]                    axi_ctrl_bresp,
  input  logic                          axi_ctrl_bvalid,
  output logic                          axi_ctrl_bready,
  output logic [AXI_ADDR_BITS-1:0]      axi_ctrl_araddr,
  output logic [2:0]                    axi_ctrl_arprot,
  output logic                          axi_ctrl_arvalid,
  input  logic                          axi_ctrl_arready,
  input  logic [AXIL_DATA_BITS-1:0]     axi_ctrl_rdata,
  input  logic [1:0]                    axi_ctrl_rresp,
  input  logic                          axi_ctrl_rvalid,
  output logic                          axi_ctrl_rready
);

  localparam int TO_BITS = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The counter hits TIMEOUT_CYCLES-1 on the edge that moves us into RESP.
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'((TIMEOUT_CYCLES >= 2) ? (TIMEOUT_CYCLES - 2) : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t                      state_r, state_nxt_s;
  logic                        cmd_ready_r, cmd_ready_nxt_s;
  logic                        rsp_valid_r, rsp_valid_nxt_s;
  logic                        awvalid_r, awvalid_nxt_s;
  logic                        wvalid_r, wvalid_nxt_s;
  logic                        arvalid_r, arvalid_nxt_s;
  logic                        ready_r;
  logic                        got_r, got_nxt_s;
  logic [TO_BITS-1:0]          to_cnt_r, to_cnt_nxt_s;
  logic [AXI_ADDR_BITS-1:0]    addr_r, addr_nxt_s;
  logic [AXIL_DATA_BITS-1:0]   data_r, data_nxt_s;
  logic [AXIL_DATA_BITS/8-1:0] strb_r, strb_nxt_s;
  logic [AXIL_DATA_BITS-1:0]   rsp_data_r, rsp_data_nxt_s;
  logic [1:0]                  rsp_resp_r, rsp_resp_nxt_s;
  logic                        rsp_timeout_r, rsp_timeout_nxt_s;
  logic [STALE_CNT_BITS-1:0]   stale_r, stale_nxt_s;
  logic [STALE_CNT_BITS:0]     stale_sum_s;
  logic [1:0]                  stale_inc_s;

  logic cmd_hs_s, wr_last_s, ar_hs_s, b_take_s, r_take_s, timeout_s, b_stale_s, r_stale_s;

  assign cmd_hs_s  = (state_r == IDLE) && cmd_ready_r && cmd_valid;
  assign wr_last_s = (state_r == WR_REQ) && (!awvalid_r || axi_ctrl_awready) && (!wvalid_r || axi_ctrl_wready);
  assign ar_hs_s   = arvalid_r && axi_ctrl_arready;
  // got_r remembers a response that arrived together with the final request handshake.
  assign b_take_s  = axi_ctrl_bvalid && ready_r && !got_r && (wr_last_s || (state_r == WR_RESP));
  assign r_take_s  = axi_ctrl_rvalid && ready_r && !got_r && (((state_r == RD_REQ) && ar_hs_s) || (state_r == RD_DATA));
  assign timeout_s = (TIMEOUT_CYCLES != 0) && (to_cnt_r == TO_LAST);
  assign b_stale_s = axi_ctrl_bvalid && ready_r && (state_r != WR_REQ) && (state_r != WR_RESP);
  assign r_stale_s = axi_ctrl_rvalid && ready_r && (state_r != RD_REQ) && (state_r != RD_DATA);

  assign stale_inc_s = {1'b0, b_stale_s} + {1'b0, r_stale_s};
  assign stale_sum_s = {1'b0, stale_r} + {{(STALE_CNT_BITS-1){1'b0}}, stale_inc_s};
  assign stale_nxt_s = stale_sum_s[STALE_CNT_BITS] ? {STALE_CNT_BITS{1'b1}} : stale_sum_s[STALE_CNT_BITS-1:0];

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cmd_ready_r   <= 1'b0;
      rsp_valid_r   <= 1'b0;
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      arvalid_r     <= 1'b0;
      ready_r       <= 1'b0;
      got_r         <= 1'b0;
      to_cnt_r      <= {TO_BITS{1'b0}};
      addr_r        <= {AXI_ADDR_BITS{1'b0}};
      data_r        <= {AXIL_DATA_BITS{1'b0}};
      strb_r        <= {(AXIL_DATA_BITS/8){1'b0}};
      rsp_data_r    <= {AXIL_DATA_BITS{1'b0}};
      rsp_resp_r    <= 2'b00;
      rsp_timeout_r <= 1'b0;
      stale_r       <= {STALE_CNT_BITS{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      cmd_ready_r   <= cmd_ready_nxt_s;
      rsp_valid_r   <= rsp_valid_nxt_s;
      awvalid_r     <= awvalid_nxt_s;
      wvalid_r      <= wvalid_nxt_s;
      arvalid_r     <= arvalid_nxt_s;
      ready_r       <= 1'b1;
      got_r         <= got_nxt_s;
      to_cnt_r      <= to_cnt_nxt_s;
      addr_r        <= addr_nxt_s;
      data_r        <= data_nxt_s;
      strb_r        <= strb_nxt_s;
      rsp_data_r    <= rsp_data_nxt_s;
      rsp_resp_r    <= rsp_resp_nxt_s;
      rsp_timeout_r <= rsp_timeout_nxt_s;
      stale_r       <= stale_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_hs_s) state_nxt_s = cmd_write ? WR_REQ : RD_REQ;
        else          state_nxt_s = IDLE;
      end
      WR_REQ: begin
        if (wr_last_s) state_nxt_s = WR_RESP;
        else           state_nxt_s = WR_REQ;
      end
      WR_RESP: begin
        if (got_r || b_take_s || timeout_s) state_nxt_s = RESP;
        else                                state_nxt_s = WR_RESP;
      end
      RD_REQ: begin
        if (ar_hs_s) state_nxt_s = RD_DATA;
        else         state_nxt_s = RD_REQ;
      end
      RD_DATA: begin
        if (got_r || r_take_s || timeout_s) state_nxt_s = RESP;
        else                                state_nxt_s = RD_DATA;
      end
      RESP: begin
        if (rsp_valid_r && rsp_ready) state_nxt_s = IDLE;
        else                          state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output/datapath next values; the first cycle of IDLE and RESP is a bubble.
  always_comb begin
    cmd_ready_nxt_s   = (state_r == IDLE) && (state_nxt_s == IDLE);
    rsp_valid_nxt_s   = (state_r == RESP) && (state_nxt_s == RESP);
    awvalid_nxt_s     = awvalid_r;
    wvalid_nxt_s      = wvalid_r;
    arvalid_nxt_s     = arvalid_r;
    got_nxt_s         = got_r;
    to_cnt_nxt_s      = to_cnt_r;
    addr_nxt_s        = addr_r;
    data_nxt_s        = data_r;
    strb_nxt_s        = strb_r;
    rsp_data_nxt_s    = rsp_data_r;
    rsp_resp_nxt_s    = rsp_resp_r;
    rsp_timeout_nxt_s = rsp_timeout_r;
    case (state_r)
      IDLE: begin
        got_nxt_s = 1'b0;
        if (cmd_hs_s) begin
          addr_nxt_s    = {cmd_addr, {ADDR_LSB{1'b0}}};
          data_nxt_s    = cmd_data;
          strb_nxt_s    = cmd_strb;
          awvalid_nxt_s = cmd_write;
          wvalid_nxt_s  = cmd_write;
          arvalid_nxt_s = !cmd_write;
        end else begin
          addr_nxt_s = addr_r;
        end
      end
      WR_REQ: begin
        to_cnt_nxt_s  = {TO_BITS{1'b0}};
        awvalid_nxt_s = awvalid_r && !axi_ctrl_awready;
        wvalid_nxt_s  = wvalid_r && !axi_ctrl_wready;
        if (b_take_s) begin
          rsp_data_nxt_s    = {AXIL_DATA_BITS{1'b0}};
          rsp_resp_nxt_s    = axi_ctrl_bresp;
          rsp_timeout_nxt_s = 1'b0;
          got_nxt_s         = 1'b1;
        end else begin
          got_nxt_s = got_r;
        end
      end
      WR_RESP: begin
        if (got_r) begin
          to_cnt_nxt_s = to_cnt_r;
        end else if (b_take_s) begin
          rsp_data_nxt_s    = {AXIL_DATA_BITS{1'b0}};
          rsp_resp_nxt_s    = axi_ctrl_bresp;
          rsp_timeout_nxt_s = 1'b0;
        end else if (timeout_s) begin
          rsp_data_nxt_s    = {AXIL_DATA_BITS{1'b0}};
          rsp_resp_nxt_s    = 2'b10;
          rsp_timeout_nxt_s = 1'b1;
        end else begin
          to_cnt_nxt_s = to_cnt_r + 1'b1;
        end
      end
      RD_REQ: begin
        to_cnt_nxt_s  = {TO_BITS{1'b0}};
        arvalid_nxt_s = arvalid_r && !axi_ctrl_arready;
        if (r_take_s) begin
          rsp_data_nxt_s    = axi_ctrl_rdata;
          rsp_resp_nxt_s    = axi_ctrl_rresp;
          rsp_timeout_nxt_s = 1'b0;
          got_nxt_s         = 1'b1;
        end else begin
          got_nxt_s = got_r;
        end
      end
      RD_DATA: begin
        if (got_r) begin
          to_cnt_nxt_s = to_cnt_r;
        end else if (r_take_s) begin
          rsp_data_nxt_s    = axi_ctrl_rdata;
          rsp_resp_nxt_s    = axi_ctrl_rresp;
          rsp_timeout_nxt_s = 1'b0;
        end else if (timeout_s) begin
          rsp_data_nxt_s    = {AXIL_DATA_BITS{1'b0}};
          rsp_resp_nxt_s    = 2'b10;
          rsp_timeout_nxt_s = 1'b1;
        end else begin
          to_cnt_nxt_s = to_cnt_r + 1'b1;
        end
      end
      RESP: begin
        got_nxt_s = got_r;
      end
      default: begin
        got_nxt_s = 1'b0;
      end
    endcase
  end

  assign cmd_ready        = cmd_ready_r;
  assign rsp_valid        = rsp_valid_r;
  assign rsp_data         = rsp_data_r;
  assign rsp_resp         = rsp_resp_r;
  assign rsp_timeout      = rsp_timeout_r;
  assign stale_cnt        = stale_r;
  assign axi_ctrl_awaddr  = addr_r;
  assign axi_ctrl_araddr  = addr_r;
  assign axi_ctrl_awprot  = 3'b000;
  assign axi_ctrl_arprot  = 3'b000;
  assign axi_ctrl_awvalid = awvalid_r;
  assign axi_ctrl_wvalid  = wvalid_r;
  assign axi_ctrl_arvalid = arvalid_r;
  assign axi_ctrl_wdata   = data_r;
  assign axi_ctrl_wstrb   = strb_r;
  assign axi_ctrl_bready  = ready_r;
  assign axi_ctrl_rready  = ready_r;

endmodule

// File: tb/tb_axil_config_master.sv
// Directed bench for axil_config_master: a hand-driven slave, fixed expected values.
module tb_axil_config_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [28:0] cmd_addr;
  logic [63:0] cmd_data;
  logic [7:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [15:0] stale_cnt;
  logic [31:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axil_config_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .stale_cnt(stale_cnt),
    .axi_ctrl_awaddr(awaddr), .axi_ctrl_awprot(awprot), .axi_ctrl_awvalid(awvalid),
    .axi_ctrl_awready(awready), .axi_ctrl_wdata(wdata), .axi_ctrl_wstrb(wstrb),
    .axi_ctrl_wvalid(wvalid), .axi_ctrl_wready(wready), .axi_ctrl_bresp(bresp),
    .axi_ctrl_bvalid(bvalid), .axi_ctrl_bready(bready), .axi_ctrl_araddr(araddr),
    .axi_ctrl_arprot(arprot), .axi_ctrl_arvalid(arvalid), .axi_ctrl_arready(arready),
    .axi_ctrl_rdata(rdata), .axi_ctrl_rresp(rresp), .axi_ctrl_rvalid(rvalid),
    .axi_ctrl_rready(rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 29'd0;
    cmd_data = 64'd0; cmd_strb = 8'd0; rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = 64'd0; rresp = 2'b00;

    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_valids", {61'd0, awvalid, wvalid, arvalid}, 64'd0);
    chk("rst_bready", {63'd0, bready}, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_stale", {48'd0, stale_cnt}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("post_rst_ready", {62'd0, bready, rready}, 64'd3);

    // Write idx 5, slave ready immediately, bvalid with the AW/W handshake
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 29'h5;
    cmd_data = 64'hDEADBEEF_01234567; cmd_strb = 8'hFF;
    tick();
    cmd_valid = 1'b0;
    chk("w1_awaddr", {32'd0, awaddr}, 64'h28);
    chk("w1_wdata", wdata, 64'hDEADBEEF_01234567);
    chk("w1_wstrb", {56'd0, wstrb}, 64'hFF);
    chk("w1_valids", {62'd0, awvalid, wvalid}, 64'd3);
    chk("w1_prot", {58'd0, awprot, arprot}, 64'd0);
    chk("w1_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    tick();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    chk("w1_valids_drop", {62'd0, awvalid, wvalid}, 64'd0);
    tick();
    chk("w1_rsp_not_yet", {63'd0, rsp_valid}, 64'd0);
    tick();
    chk("w1_rsp_valid_c4", {63'd0, rsp_valid}, 64'd1);
    chk("w1_rsp_resp", {62'd0, rsp_resp}, 64'd0);
    chk("w1_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    chk("w1_rsp_data", rsp_data, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("w1_rsp_done", {63'd0, rsp_valid}, 64'd0);
    chk("w1_bubble", {63'd0, cmd_ready}, 64'd0);
    tick();
    chk("w1_idle_ready", {63'd0, cmd_ready}, 64'd1);

    // Write with awready three cycles ahead of wready
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 29'h7;
    cmd_data = 64'h1111_2222_3333_4444; cmd_strb = 8'h0F;
    tick();
    cmd_valid = 1'b0;
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("w2_aw_drop", {62'd0, awvalid, wvalid}, 64'd1);
    tick(); tick();
    chk("w2_w_held", {62'd0, awvalid, wvalid}, 64'd1);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    chk("w2_w_drop", {63'd0, wvalid}, 64'd0);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    tick();
    chk("w2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("w2_rsp_resp", {62'd0, rsp_resp}, 64'd0);
    chk("w2_stale", {48'd0, stale_cnt}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();

    // Read idx 2 returning SLVERR
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 29'h2;
    tick();
    cmd_valid = 1'b0;
    chk("r1_araddr", {32'd0, araddr}, 64'h10);
    chk("r1_arvalid", {62'd0, arvalid, awvalid}, 64'd2);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("r1_ar_drop", {63'd0, arvalid}, 64'd0);
    rvalid = 1'b1; rdata = 64'hCAFE; rresp = 2'b10;
    tick();
    rvalid = 1'b0;
    tick();
    chk("r1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("r1_rsp_data", rsp_data, 64'hCAFE);
    chk("r1_rsp_resp", {62'd0, rsp_resp}, 64'd2);
    chk("r1_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();

    // Write whose B never comes: timeout after 8 cycles in WR_RESP
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 29'h1; cmd_strb = 8'h01;
    tick();
    cmd_valid = 1'b0;
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("to_not_yet", {63'd0, rsp_valid}, 64'd0);
    tick();
    chk("to_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("to_rsp_timeout", {63'd0, rsp_timeout}, 64'd1);
    chk("to_rsp_resp", {62'd0, rsp_resp}, 64'd2);
    chk("to_rsp_data", rsp_data, 64'd0);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("to_stale_late_b", {48'd0, stale_cnt}, 64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();

    // Read with rvalid alongside arready, then rsp_ready stalled with a command pending
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 29'h3;
    tick();
    cmd_valid = 1'b0;
    arready = 1'b1; rvalid = 1'b1; rdata = 64'h1234_5678; rresp = 2'b00;
    tick();
    arready = 1'b0; rvalid = 1'b0;
    tick(); tick();
    chk("st_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("st_rsp_data", rsp_data, 64'h1234_5678);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 29'h9;
    cmd_data = 64'hA5A5; cmd_strb = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_hold_valid", {63'd0, rsp_valid}, 64'd1);
      chk("st_hold_data", rsp_data, 64'h1234_5678);
      chk("st_cmd_ready", {62'd0, cmd_ready, awvalid}, 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("st_bubble", {61'd0, cmd_ready, rsp_valid, awvalid}, 64'd0);
    tick();
    chk("st_ready_again", {62'd0, cmd_ready, awvalid}, 64'd2);
    tick();
    cmd_valid = 1'b0;
    chk("st_new_cmd_aw", {62'd0, awvalid, wvalid}, 64'd3);
    chk("st_new_cmd_addr", {32'd0, awaddr}, 64'h48);
    chk("st_zero_strb", {56'd0, wstrb}, 64'd0);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b11;
    tick();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    tick(); tick();
    chk("st_w_rsp_resp", {61'd0, rsp_valid, rsp_resp}, 64'h7);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();

    // Reset pulse while in RD_REQ
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 29'h4;
    tick();
    cmd_valid = 1'b0;
    chk("rr_arvalid", {63'd0, arvalid}, 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rr_arvalid_clr", {63'd0, arvalid}, 64'd0);
    chk("rr_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rr_stale_clr", {48'd0, stale_cnt}, 64'd0);
    tick();
    chk("rr_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    tick(); tick();
    chk("rr_quiet", {62'd0, rsp_valid, arvalid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
